// File: rtl/seq_restoring_divider.sv
// Iterative unsigned restoring divider: one quotient bit per clock.
// Result is packed as {remainder, quotient}; divide-by-zero finishes in one cycle.
module seq_restoring_divider #(
    parameter int N = 8
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic [N-1:0]   x,
    input  logic [N-1:0]   y,
    output logic           busy,
    output logic           done,
    output logic           div_by_zero,
    output logic [2*N-1:0] result
);

    localparam int CW = $clog2(N) + 1;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t        state;
    state_t        state_next;
    logic [N-1:0]  rem;
    logic [N-1:0]  quo;
    logic [N-1:0]  dvs;
    logic [CW-1:0] count;
    logic [N:0]    trial;
    logic [N-1:0]  rem_next;
    logic [N-1:0]  quo_next;
    logic          last_iter;
    logic          accept;

    // Trial subtraction is one bit wider than the operands so a partial
    // remainder at or above 2^(N-1) still shifts without losing its MSB.
    always_comb begin
        trial     = {rem, quo[N-1]} - {1'b0, dvs};
        rem_next  = {rem[N-2:0], quo[N-1]};
        quo_next  = {quo[N-2:0], 1'b0};
        if (!trial[N]) begin
            rem_next = trial[N-1:0];
            quo_next = {quo[N-2:0], 1'b1};
        end
        last_iter = (count == CW'(N - 1));
        accept    = (state == IDLE) && start;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = (y == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                busy = 1'b1;
                if (last_iter) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Working registers and the visible result; result only moves on completion.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rem         <= '0;
            quo         <= '0;
            dvs         <= '0;
            count       <= '0;
            div_by_zero <= 1'b0;
            result      <= '0;
        end else if (accept) begin
            if (y == '0) begin
                div_by_zero <= 1'b1;
                result      <= {x, {N{1'b1}}};
            end else begin
                rem         <= '0;
                quo         <= x;
                dvs         <= y;
                count       <= '0;
                div_by_zero <= 1'b0;
            end
        end else if (state == RUN) begin
            rem   <= rem_next;
            quo   <= quo_next;
            count <= count + CW'(1);
            if (last_iter) begin
                result <= {rem_next, quo_next};
            end
        end
    end

endmodule

// File: tb/tb_seq_restoring_divider.sv
// Randomised self-checking bench for seq_restoring_divider (N=8) against an
// arithmetic reference of {x % y, x / y}, with directed corner cases first.
module tb_seq_restoring_divider;

    localparam int N = 8;

    logic           clk;
    logic           rst;
    logic           start;
    logic [N-1:0]   x;
    logic [N-1:0]   y;
    logic           busy;
    logic           done;
    logic           div_by_zero;
    logic [2*N-1:0] result;

    int checks;
    int errors;
    logic [2*N-1:0] last_result;

    seq_restoring_divider #(.N(N)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .x          (x),
        .y          (y),
        .busy       (busy),
        .done       (done),
        .div_by_zero(div_by_zero),
        .result     (result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: plain integer division, all-ones quotient on zero divisor.
    function automatic logic [2*N-1:0] model(input logic [N-1:0] a, input logic [N-1:0] b);
        int ia;
        int ib;
        logic [N-1:0] q;
        logic [N-1:0] r;
        ia = int'(a);
        ib = int'(b);
        if (ib == 0) begin
            return {a, {N{1'b1}}};
        end
        q = N'(ia / ib);
        r = N'(ia % ib);
        return {r, q};
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, observed, expected, $time);
        end
    endtask

    // Launches one operation from IDLE (called #1 after an edge) and checks
    // busy, latency, result, flag and the one-cycle done pulse.
    // When hold_junk is set, a bogus request is kept asserted during RUN/DONE.
    task automatic applyStimulus(input logic [N-1:0] a, input logic [N-1:0] b, input bit hold_junk);
        int cyc;
        logic [2*N-1:0] exp;
        exp   = model(a, b);
        start = 1'b1;
        x     = a;
        y     = b;
        @(posedge clk);
        #1;
        if (hold_junk) begin
            x = 8'd1;
            y = 8'd1;
        end else begin
            start = 1'b0;
            x     = 8'($urandom);
            y     = 8'($urandom);
        end
        if (b != 0) begin
            checkOutput("busy_after_start", 32'(busy), 32'd1);
            checkOutput("result_held_in_run", 32'(result), 32'(last_result));
        end
        cyc = 0;
        while (!done && cyc < 40) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        checkOutput("latency", 32'(cyc), (b == 0) ? 32'd0 : 32'(N));
        checkOutput("result", 32'(result), 32'(exp));
        checkOutput("div_by_zero", 32'(div_by_zero), (b == 0) ? 32'd1 : 32'd0);
        checkOutput("busy_in_done", 32'(busy), 32'd0);
        last_result = exp;
        start = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("done_one_cycle", 32'(done), 32'd0);
        checkOutput("result_held_idle", 32'(result), 32'(exp));
    endtask

    initial begin
        logic [N-1:0] ra;
        logic [N-1:0] rb;
        checks      = 0;
        errors      = 0;
        last_result = '0;
        rst         = 1'b1;
        start       = 1'b0;
        x           = '0;
        y           = '0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset_busy", 32'(busy), 32'd0);
        checkOutput("reset_done", 32'(done), 32'd0);
        checkOutput("reset_dbz", 32'(div_by_zero), 32'd0);
        checkOutput("reset_result", 32'(result), 32'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        applyStimulus(8'd100, 8'd7, 1'b0);
        checkOutput("const_100_7", 32'(result), 32'h020E);
        applyStimulus(8'd255, 8'd1, 1'b0);
        checkOutput("const_255_1", 32'(result), 32'h00FF);
        applyStimulus(8'd255, 8'd255, 1'b0);
        checkOutput("const_255_255", 32'(result), 32'h0001);
        applyStimulus(8'd200, 8'd129, 1'b0);
        checkOutput("const_200_129", 32'(result), 32'h4701);
        applyStimulus(8'd5, 8'd9, 1'b0);
        checkOutput("const_5_9", 32'(result), 32'h0500);
        applyStimulus(8'd0, 8'd3, 1'b0);
        checkOutput("const_0_3", 32'(result), 32'h0000);
        applyStimulus(8'd42, 8'd0, 1'b0);
        checkOutput("const_42_0", 32'(result), 32'h2AFF);
        applyStimulus(8'd9, 8'd3, 1'b0);
        checkOutput("const_9_3", 32'(result), 32'h0003);
        applyStimulus(8'd50, 8'd5, 1'b1);
        checkOutput("ignored_restart", 32'(result), 32'h000A);
        applyStimulus(8'd77, 8'd4, 1'b0);

        // Asynchronous reset in the 4th RUN cycle.
        start = 1'b1;
        x     = 8'd100;
        y     = 8'd7;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("async_rst_busy", 32'(busy), 32'd0);
        checkOutput("async_rst_done", 32'(done), 32'd0);
        checkOutput("async_rst_result", 32'(result), 32'd0);
        checkOutput("async_rst_dbz", 32'(div_by_zero), 32'd0);
        @(posedge clk);
        #1;
        rst         = 1'b0;
        last_result = '0;
        @(posedge clk);
        #1;
        applyStimulus(8'd100, 8'd7, 1'b0);
        checkOutput("after_reset_100_7", 32'(result), 32'h020E);

        for (int i = 0; i < 2000; i++) begin
            ra = 8'($urandom);
            rb = ($urandom_range(0, 15) == 0) ? 8'd0 : 8'($urandom);
            applyStimulus(ra, rb, ($urandom_range(0, 7) == 0));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
